// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operation class handed to the decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Datapath mux encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that hold a memory request open
    function automatic logic is_req_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode from operation class and funct fields.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] aluctrl_c,
    output logic       illegal_c
);

    // Select ALU operation; unsupported funct3 flags an illegal instruction
    always_comb begin
        aluctrl_c = ALU_ADD;
        illegal_c = 1'b0;
        case (aluop)
            ALUOP_SUB: aluctrl_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  aluctrl_c = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluctrl_c = ALU_SLT;
                    3'b110:  aluctrl_c = ALU_OR;
                    3'b111:  aluctrl_c = ALU_AND;
                    default: illegal_c = 1'b1;
                endcase
            end
            default: aluctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with shared-memory handshake, timeout trap and retire counter.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 EQ,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [2:0]           ALUctrl,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instret
);

    // Wait counter only needs to reach TIMEOUT-1 before trapping
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    state_t            next_c;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        aluop_c;
    logic              illegal_c;
    logic [1:0]        cause_c;
    logic              timeout_c;
    logic              retire_c;

    assign trap      = (state == S_TRAP);
    assign timeout_c = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign retire_c  = (state != S_FETCH) && (next_c == S_FETCH);

    multicycle_controller_alu_decoder u_alu_dec (
        .aluop     (aluop_c),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .op5       (opcode[5]),
        .aluctrl_c (ALUctrl),
        .illegal_c (illegal_c)
    );

    // Operation class per state, kept apart from the decode that consumes illegal_c
    always_comb begin
        aluop_c = ALUOP_ADD;
        case (state)
            S_EXECR, S_EXECI: aluop_c = ALUOP_FUNCT;
            S_BEQ:            aluop_c = ALUOP_SUB;
            default:          aluop_c = ALUOP_ADD;
        endcase
    end

    // Next-state and Moore output decode; reset forces every enable low
    always_comb begin
        next_c    = state;
        cause_c   = CAUSE_NONE;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_I;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    next_c  = S_DECODE;
                end else if (timeout_c) begin
                    next_c  = S_TRAP;
                    cause_c = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (opcode)
                    OP_LW, OP_SW: next_c = S_MEMADR;
                    OP_R:         next_c = S_EXECR;
                    OP_I:         next_c = S_EXECI;
                    OP_BEQ:       next_c = S_BEQ;
                    OP_JAL:       next_c = S_JAL;
                    default: begin
                        next_c  = S_TRAP;
                        cause_c = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
                next_c  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    next_c = S_MEMWB;
                end else if (timeout_c) begin
                    next_c  = S_TRAP;
                    cause_c = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_MEM;
                next_c    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    next_c = S_FETCH;
                end else if (timeout_c) begin
                    next_c  = S_TRAP;
                    cause_c = CAUSE_TIMEOUT;
                end
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                if (illegal_c) begin
                    next_c  = S_TRAP;
                    cause_c = CAUSE_ILLEGAL;
                end else begin
                    next_c = S_ALUWB;
                end
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                if (illegal_c) begin
                    next_c  = S_TRAP;
                    cause_c = CAUSE_ILLEGAL;
                end else begin
                    next_c = S_ALUWB;
                end
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_ALUOUT;
                next_c    = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                ResultSrc = RES_ALUOUT;
                PCWrite   = EQ;
                next_c    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                ImmSrc    = IMM_J;
                PCWrite   = 1'b1;
                next_c    = S_ALUWB;
            end
            S_TRAP:  next_c = S_TRAP;
            default: next_c = S_FETCH;
        endcase
        if (rst) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_c;
        end
    end

    // Wait counter: counts stalled request cycles, zero on entry to every request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (is_req_state(state) && !mem_ready && (next_c == state)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Trap cause latched on the single entry into TRAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_cause <= CAUSE_NONE;
        end else if ((state != S_TRAP) && (next_c == S_TRAP)) begin
            trap_cause <= cause_c;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire_c) begin
            instret <= instret + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller.
module tb_multicycle_controller;

    localparam int unsigned CW = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [6:0]    opcode    = '0;
    logic [2:0]    funct3    = '0;
    logic          funct7b5  = 1'b0;
    logic          EQ        = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]    ALUctrl;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    multicycle_controller #(.TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .EQ         (EQ),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUctrl    (ALUctrl),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // en = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}
    typedef struct packed {
        logic [5:0] en;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] is;
        logic [2:0] alu;
    } exp_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       eq;
        logic       rdy;
        exp_t       e;
        int         ir;
    } vec_t;

    localparam exp_t E_F  = exp_t'({6'b100110, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000});
    localparam exp_t E_FW = exp_t'({6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000});
    localparam exp_t E_D  = exp_t'({6'b000000, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000});
    localparam exp_t E_WB = exp_t'({6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000});

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t ex(input logic [5:0] en, input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] rs, input logic [1:0] is, input logic [2:0] alu);
        exp_t r;
        r.en = en; r.sa = sa; r.sb = sb; r.rs = rs; r.is = is; r.alu = alu;
        return r;
    endfunction

    function automatic logic [17:0] act();
        return {trap, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUctrl};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
        end
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic eq, input logic rdy);
        @(negedge clk);
        opcode = op; funct3 = f3; funct7b5 = f7; EQ = eq; mem_ready = rdy;
        #1;
    endtask

    task automatic push(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic eq, input logic rdy, input exp_t e, input int ir);
        vec_t v;
        v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.eq = eq; v.rdy = rdy; v.e = e; v.ir = ir;
        vecs.push_back(v);
    endtask

    task automatic alu_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [2:0] alu, input int ir);
        exp_t ee;
        ee = (op == OP_R) ? ex(6'b0, 2'b10, 2'b00, 2'b00, 2'b00, alu)
                          : ex(6'b0, 2'b10, 2'b01, 2'b00, 2'b00, alu);
        push({nm, " F"},  op, f3, f7, 1'b0, 1'b1, E_F,  ir);
        push({nm, " D"},  op, f3, f7, 1'b0, 1'b1, E_D,  ir);
        push({nm, " EX"}, op, f3, f7, 1'b0, 1'b1, ee,   ir);
        push({nm, " WB"}, op, f3, f7, 1'b0, 1'b1, E_WB, ir);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Vector table, mem_ready high except one stalled fetch
        alu_instr("addi",    OP_I, 3'b000, 1'b0, 3'b000, 0);
        alu_instr("add",     OP_R, 3'b000, 1'b0, 3'b000, 1);
        alu_instr("sub",     OP_R, 3'b000, 1'b1, 3'b001, 2);
        alu_instr("slti",    OP_I, 3'b010, 1'b0, 3'b101, 3);
        alu_instr("or",      OP_R, 3'b110, 1'b0, 3'b011, 4);
        alu_instr("andi",    OP_I, 3'b111, 1'b0, 3'b010, 5);
        alu_instr("addi_f7", OP_I, 3'b000, 1'b1, 3'b000, 6);
        push("lw F",   OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_F, 7);
        push("lw D",   OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, E_D, 7);
        push("lw MA",  OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000), 7);
        push("lw RD",  OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 7);
        push("lw WB",  OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000), 7);
        push("sw F",   OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, E_F, 8);
        push("sw D",   OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, E_D, 8);
        push("sw MA",  OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, ex(6'b000000, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000), 8);
        push("sw WR",  OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, ex(6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 8);
        push("beq1 FW", OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b0, E_FW, 9);
        push("beq1 F",  OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, E_F,  9);
        push("beq1 D",  OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, E_D,  9);
        push("beq1 BR", OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, ex(6'b000010, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001), 9);
        push("beq0 F",  OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, E_F,  10);
        push("beq0 D",  OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, E_D,  10);
        push("beq0 BR", OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, ex(6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001), 10);
        push("jal F",  OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, E_F, 11);
        push("jal D",  OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, E_D, 11);
        push("jal J",  OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, ex(6'b000010, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000), 11);
        push("jal WB", OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, E_WB, 11);

        // Reset state, with mem_ready high to show it has no effect
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset enables", 32'({mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}), 32'(0));
        chk("reset trap", 32'({trap, trap_cause}), 32'(0));
        chk("reset instret", 32'(instret), 32'(0));
        mem_ready = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].eq, vecs[i].rdy);
            chk({vecs[i].name, " ctl"}, 32'(act()), 32'({1'b0, vecs[i].e}));
            chk({vecs[i].name, " instret"}, 32'(instret), 32'(vecs[i].ir));
        end

        // lw with three stall cycles in MEMRD
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(OP_LW, 3'b010, 1'b0, 1'b0, (k == 3));
            chk($sformatf("lw wait%0d req", k), 32'({mem_req, MemWrite, AdrSrc}), 32'(3'b101));
        end
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("lw memwb", 32'({RegWrite, ResultSrc, mem_req}), 32'(4'b1010));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("lw instret", 32'(instret), 32'(13));

        // sw never acknowledged: trap after four waiting cycles
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
            chk($sformatf("sw wait%0d req", k), 32'({trap, mem_req, MemWrite, AdrSrc}), 32'(4'b0111));
        end
        for (int k = 0; k < 3; k++) begin
            step(OP_SW, 3'b010, 1'b0, 1'b0, 1'(k));
            chk($sformatf("sw timeout trap%0d", k),
                32'({trap, trap_cause, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}),
                32'(9'b1_10_000000));
            chk($sformatf("sw timeout instret%0d", k), 32'(instret), 32'(13));
        end

        // Unsupported opcode
        do_reset();
        step(OP_SYS, 3'b000, 1'b0, 1'b0, 1'b1);
        chk("sys fetch", 32'(act()), 32'({1'b0, E_F}));
        step(OP_SYS, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(OP_SYS, 3'b000, 1'b0, 1'b0, 1'b1);
            chk($sformatf("sys trap%0d", k),
                32'({trap, trap_cause, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}),
                32'(9'b1_01_000000));
            chk($sformatf("sys instret%0d", k), 32'(instret), 32'(0));
        end

        // R-type funct3=001 after one good addi
        do_reset();
        repeat (4) step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
        step(OP_R, 3'b001, 1'b0, 1'b0, 1'b1);
        step(OP_R, 3'b001, 1'b0, 1'b0, 1'b1);
        step(OP_R, 3'b001, 1'b0, 1'b0, 1'b1);
        chk("rbad exec", 32'({trap, RegWrite}), 32'(0));
        for (int k = 0; k < 3; k++) begin
            step(OP_R, 3'b001, 1'b0, 1'b0, 1'b1);
            chk($sformatf("rbad trap%0d", k),
                32'({trap, trap_cause, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}),
                32'(9'b1_01_000000));
            chk($sformatf("rbad instret%0d", k), 32'(instret), 32'(1));
        end

        // Reset while a load is waiting for memory
        do_reset();
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("rstmid pre req", 32'({mem_req, AdrSrc}), 32'(2'b11));
        rst = 1'b1;
        #1;
        chk("rstmid async drop", 32'({mem_req, MemWrite, AdrSrc, RegWrite}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("rstmid fetch", 32'(act()), 32'({1'b0, E_FW}));
        chk("rstmid instret", 32'(instret), 32'(0));

        // instret wraps at 2^CW
        do_reset();
        for (int k = 0; k < 18; k++) begin
            step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
            chk($sformatf("wrap instret k%0d", k), 32'(instret), 32'(k % 16));
            repeat (3) step(OP_I, 3'b000, 1'b0, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
